// File: rtl/pixel_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pixel_write_arbiter
// Purpose  : Round-robin arbiter that gives one of three pixel producers
//            (r0 background fill, r1 note-box drawer, r2 score overlay)
//            ownership of a single framebuffer write port for a burst.
//            Accepted beats are registered onto x/y/colour/plot with one
//            cycle of latency; off-screen beats are consumed but counted
//            in a saturating drop counter instead of being plotted.
// Ports    : clock, resetn       - clock, asynchronous active-low reset
//            reqValid/reqLast    - per-requester beat valid / end-of-burst
//            reqX/reqY/reqColour - packed per-requester beat fields
//            grant               - one-hot owner (or zero when idle)
//            x, y, colour, plot  - registered framebuffer write
//            busy                - OR of grant bits
//            dropCount           - saturating count of off-screen beats
// Revision : 1.0 - initial release
// ============================================================================
module pixel_write_arbiter #(
  parameter int MAX_BURST  = 64,
  parameter int IDLE_LIMIT = 16
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [2:0]  reqValid,
  input  logic [2:0]  reqLast,
  input  logic [23:0] reqX,
  input  logic [23:0] reqY,
  input  logic [8:0]  reqColour,
  output logic [2:0]  grant,
  output logic [7:0]  x,
  output logic [7:0]  y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        busy,
  output logic [7:0]  dropCount
);

  localparam logic [6:0] c_BEAT_LAST = 7'(MAX_BURST - 1);
  localparam logic [4:0] c_IDLE_LAST = 5'(IDLE_LIMIT - 1);
  localparam logic [7:0] c_X_LIMIT   = 8'd240;
  localparam logic [7:0] c_Y_LIMIT   = 8'd180;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t      r_state;
  logic [1:0]  r_owner;
  logic [1:0]  r_last_owner;
  logic [2:0]  r_grant;
  logic [6:0]  r_beat_cnt;
  logic [4:0]  r_idle_cnt;
  logic [7:0]  r_x;
  logic [7:0]  r_y;
  logic [2:0]  r_colour;
  logic        r_plot;
  logic [7:0]  r_drop_cnt;

  logic        w_own_valid;
  logic        w_own_last;
  logic [7:0]  w_own_x;
  logic [7:0]  w_own_y;
  logic [2:0]  w_own_colour;
  logic        w_accept;
  logic        w_in_range;
  logic        w_burst_end;
  logic [1:0]  w_rr_start;
  logic [1:0]  w_winner;
  logic        w_win_found;

  // Fields of the current owner; r_owner never holds 3, default covers it.
  always_comb begin
    w_own_valid  = 1'b0;
    w_own_last   = 1'b0;
    w_own_x      = 8'd0;
    w_own_y      = 8'd0;
    w_own_colour = 3'd0;
    case (r_owner)
      2'd0: begin
        w_own_valid  = reqValid[0];
        w_own_last   = reqLast[0];
        w_own_x      = reqX[7:0];
        w_own_y      = reqY[7:0];
        w_own_colour = reqColour[2:0];
      end
      2'd1: begin
        w_own_valid  = reqValid[1];
        w_own_last   = reqLast[1];
        w_own_x      = reqX[15:8];
        w_own_y      = reqY[15:8];
        w_own_colour = reqColour[5:3];
      end
      2'd2: begin
        w_own_valid  = reqValid[2];
        w_own_last   = reqLast[2];
        w_own_x      = reqX[23:16];
        w_own_y      = reqY[23:16];
        w_own_colour = reqColour[8:6];
      end
      default: begin
        w_own_valid  = 1'b0;
      end
    endcase
  end

  assign w_accept   = (r_state == S_BURST) && w_own_valid;
  assign w_in_range = (w_own_x < c_X_LIMIT) && (w_own_y < c_Y_LIMIT);

  // Burst ends on a last beat, on the final allowed beat, or when the owner
  // has been silent for IDLE_LIMIT consecutive granted cycles.
  assign w_burst_end = (w_accept && (w_own_last || (r_beat_cnt == c_BEAT_LAST))) ||
                       ((r_state == S_BURST) && !w_own_valid && (r_idle_cnt == c_IDLE_LAST));

  // Round-robin search starts just after the previous owner, modulo 3.
  assign w_rr_start = (r_last_owner == 2'd2) ? 2'd0 : (r_last_owner + 2'd1);

  always_comb begin
    w_winner    = 2'd0;
    w_win_found = 1'b0;
    for (int k = 0; k < 3; k++) begin
      int idx;
      idx = int'(w_rr_start) + k;
      if (idx >= 3) idx = idx - 3;
      if (!w_win_found && reqValid[idx]) begin
        w_win_found = 1'b1;
        w_winner    = 2'(idx);
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_owner      <= 2'd0;
      r_last_owner <= 2'd2;
      r_grant      <= 3'b000;
      r_beat_cnt   <= 7'd0;
      r_idle_cnt   <= 5'd0;
      r_x          <= 8'd0;
      r_y          <= 8'd0;
      r_colour     <= 3'd0;
      r_plot       <= 1'b0;
      r_drop_cnt   <= 8'd0;
    end else begin
      r_plot <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_win_found) begin
            r_state    <= S_BURST;
            r_owner    <= w_winner;
            r_grant    <= 3'b001 << w_winner;
            r_beat_cnt <= 7'd0;
            r_idle_cnt <= 5'd0;
          end
        end
        S_BURST: begin
          if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + 7'd1;
            r_idle_cnt <= 5'd0;
            if (w_in_range) begin
              r_plot   <= 1'b1;
              r_x      <= w_own_x;
              r_y      <= w_own_y;
              r_colour <= w_own_colour;
            end else if (r_drop_cnt != 8'hFF) begin
              r_drop_cnt <= r_drop_cnt + 8'd1;
            end
          end else begin
            r_idle_cnt <= r_idle_cnt + 5'd1;
          end
          if (w_burst_end) begin
            r_state      <= S_IDLE;
            r_grant      <= 3'b000;
            r_last_owner <= r_owner;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_grant <= 3'b000;
        end
      endcase
    end
  end

  assign grant     = r_grant;
  assign busy      = |r_grant;
  assign x         = r_x;
  assign y         = r_y;
  assign colour    = r_colour;
  assign plot      = r_plot;
  assign dropCount = r_drop_cnt;

endmodule
`default_nettype wire

// File: doc/pixel_write_arbiter.md
PIXEL_WRITE_ARBITER -- requirements
Module: pixel_write_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 64: accepted beats per grant before forced release.
REQ-002 Parameter IDLE_LIMIT, default 16: consecutive granted cycles with no valid beat before forced release.
REQ-003 clock  input  1  single clock; all state changes on the rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 reqValid  input  3  per-requester beat valid; r0 = background fill, r1 = note-box drawer, r2 = score overlay.
REQ-006 reqLast  input  3  per-requester end-of-burst flag; only meaningful with reqValid.
REQ-007 reqX  input  24  packed x coordinates, 8 bits per requester, requester r at bits [8r+7:8r].
REQ-008 reqY  input  24  packed y coordinates, 8 bits per requester.
REQ-009 reqColour  input  9  packed colours, 3 bits per requester.
REQ-010 grant  output  3  one-hot or zero; grant[r]=1 means requester r owns the write port.
REQ-011 x, y  output  8 each  registered framebuffer write address.
REQ-012 colour  output  3  registered framebuffer write colour.
REQ-013 plot  output  1  registered framebuffer write enable.
REQ-014 busy  output  1  high while any grant is active.
REQ-015 dropCount  output  8  saturating count of off-screen beats.

Function
REQ-016 Two states: IDLE and BURST.
REQ-017 Beat accepted: the cycle in which grant[r]=1 and reqValid[r]=1.
REQ-018 IDLE: grant=0.
REQ-019 IDLE with any reqValid high: select the winner round-robin.
- Search order starts at lastOwner+1 mod 3.
- Next state is BURST with grant one-hot on the winner, effective the next cycle.
REQ-020 IDLE with no reqValid high: stay in IDLE.
REQ-021 BURST ends on the first of:
- an accepted beat with reqLast[r]=1;
- the MAX_BURST-th accepted beat of the grant;
- IDLE_LIMIT consecutive granted cycles with reqValid[r]=0.
REQ-022 On burst end: next state IDLE, grant=0 the next cycle, lastOwner updated to r.
- Minimum gap between grants is one IDLE cycle.
REQ-023 Beat counter (7 bits) and idle counter (5 bits):
- both cleared on entry to BURST;
- the idle counter also clears on any accepted beat.
REQ-024 Accepted beat with x<240 and y<180:
- x, y, colour take requester r's fields the next cycle;
- plot=1 for exactly that cycle (latency 1).
REQ-025 Accepted beat with x>=240 or y>=180:
- still accepted; plot stays 0;
- dropCount increments, saturating at 255.
REQ-026 No accepted beat in a cycle: plot=0 the next cycle; x, y, colour hold their values.
REQ-027 Requests from non-granted requesters are ignored and never produce a write; the arbiter does not buffer them.
REQ-028 A simultaneous reqValid rise and burst end: no effect on the current burst; arbitration occurs in IDLE.
REQ-029 busy equals the OR of the grant bits.

Reset
REQ-030 While resetn=0, asynchronously:
- state=IDLE, grant=0, plot=0, busy=0;
- x=0, y=0, colour=0, dropCount=0;
- lastOwner=2, so r0 wins first;
- beat and idle counters = 0.
REQ-031 Reset asserted mid-burst: the burst aborts immediately; no plot after resetn rises until a new grant.
REQ-032 First arbitration occurs on the first rising edge with resetn=1.

Verification
REQ-033 After reset, reqValid=3'b111 held, every beat reqLast=1 -> grant sequence 001,000,010,000,100,000,001.
REQ-034 r1 granted, beats (10,20,c=5) then (11,20,c=5,last) -> plot=1 on the two cycles after acceptance with x=10 then 11, y=20, colour=5; grant=0 on the following cycle.
REQ-035 r0 streams 70 beats, reqLast never set, r1 also requesting -> r0 released after 64 accepted beats; r1 granted after one IDLE cycle.
REQ-036 r2 granted then reqValid dropped -> grant released after 16 idle cycles; plot stays 0 throughout.
REQ-037 Beats at (240,0), (0,180), (239,179) -> dropCount=2; only (239,179) plotted.
REQ-038 resetn pulsed low during the beat-5 cycle of a burst -> grant and plot are 0 within that cycle; dropCount=0 after reset.
